// File: rtl/mux_arb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_pipe
// Description : N-to-1 channel multiplexer with explicit-select or
//               round-robin arbitration, feeding a single registered
//               valid/ready output stage (one-cycle latency, full throughput).
// Revision    : 1.0 - initial release
// ============================================================================
module mux_arb_pipe #(
    parameter int WIDTH = 18,
    parameter int N     = 3,
    localparam int SW   = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SW-1:0]        sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // N widened by one bit so an out-of-range sel can be compared without loss
    localparam logic [SW:0]   C_N_EXT = (SW+1)'(N);
    localparam logic [SW-1:0] C_LAST  = SW'(N-1);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SW-1:0]      out_chan_q, out_chan_d;
    logic [SW-1:0]      rr_ptr_q, rr_ptr_d;

    logic [N-1:0]       w_grant;
    logic [SW-1:0]      w_gidx;
    logic               w_found;
    int                 w_idx;
    logic               w_load_en;
    logic               w_xfer;

    // Output register may take a new beat when empty or draining this cycle
    assign w_load_en = (state_q == EMPTY) | out_ready;
    assign in_ready  = w_grant & {N{w_load_en & ~rst}};
    // A grant implies the channel is valid, so any ready bit is a transfer
    assign w_xfer    = |in_ready;

    // Grant selection: explicit sel in mode 0, rotating priority from rr_ptr in mode 1
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        if (!mode) begin
            if (({1'b0, sel} < C_N_EXT) && in_valid[sel]) begin
                w_grant[sel] = 1'b1;
                w_gidx       = sel;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                w_idx = int'(rr_ptr_q) + k;
                if (w_idx >= N) begin
                    w_idx = w_idx - N;
                end
                if (!w_found && in_valid[w_idx]) begin
                    w_found        = 1'b1;
                    w_grant[w_idx] = 1'b1;
                    w_gidx         = SW'(w_idx);
                end
            end
        end
    end

    // Next-state for the output stage and the round-robin pointer
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_chan_d = out_chan_q;
        rr_ptr_d   = rr_ptr_q;
        if (w_xfer) begin
            out_data_d = in_data[int'(w_gidx)*WIDTH +: WIDTH];
            out_chan_d = w_gidx;
            state_d    = FULL;
            if (mode) begin
                rr_ptr_d = (w_gidx == C_LAST) ? '0 : w_gidx + 1'b1;
            end
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    // State registers; reset discards any held beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_chan_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_chan_q <= out_chan_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_arb_pipe
// Description : Directed self-checking bench for mux_arb_pipe (WIDTH=18, N=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_arb_pipe;

    localparam int WIDTH = 18;
    localparam int N     = 3;
    localparam int SW    = 2;

    logic                 clk;
    logic                 rst;
    logic                 mode;
    logic [SW-1:0]        sel;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SW-1:0]        out_chan;
    logic                 out_valid;
    logic                 out_ready;

    int n_checks;
    int n_errors;

    localparam logic [WIDTH-1:0] D0 = 18'h3FFFF;
    localparam logic [WIDTH-1:0] D1 = 18'h00011;
    localparam logic [WIDTH-1:0] D2 = 18'h2A5A5;

    mux_arb_pipe #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected round-robin channel order with all inputs valid
    logic [SW-1:0] rr_seq [5];
    logic [WIDTH-1:0] dat_by_ch [3];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rr_seq[0] = 2'd0; rr_seq[1] = 2'd1; rr_seq[2] = 2'd2;
        rr_seq[3] = 2'd0; rr_seq[4] = 2'd1;
        dat_by_ch[0] = D0; dat_by_ch[1] = D1; dat_by_ch[2] = D2;

        // V1: reset with all channels valid
        rst       = 1'b1;
        mode      = 1'b1;
        sel       = 2'd0;
        in_data   = {D2, D1, D0};
        in_valid  = 3'b111;
        out_ready = 1'b1;
        tick();
        tick();
        chk("v1_in_ready", 64'(in_ready), 64'h0);
        chk("v1_out_valid", 64'(out_valid), 64'h0);
        chk("v1_out_data", 64'(out_data), 64'h0);
        chk("v1_out_chan", 64'(out_chan), 64'h0);

        // V2: explicit select of channel 2
        rst  = 1'b0;
        mode = 1'b0;
        sel  = 2'd2;
        #1;
        chk("v2_in_ready", 64'(in_ready), 64'h4);
        tick();
        chk("v2_out_valid", 64'(out_valid), 64'h1);
        chk("v2_out_data", 64'(out_data), 64'h2A5A5);
        chk("v2_out_chan", 64'(out_chan), 64'h2);
        chk("v2_in_ready_again", 64'(in_ready), 64'h4);

        // Mode 0: selected channel not valid gives no grant regardless of others
        sel      = 2'd0;
        in_valid = 3'b110;
        #1;
        chk("m0_sel_invalid", 64'(in_ready), 64'h0);
        in_valid = 3'b111;

        // V3: illegal select drains the held beat and loads nothing
        sel = 2'd3;
        #1;
        chk("v3_in_ready", 64'(in_ready), 64'h0);
        tick();
        chk("v3_out_valid", 64'(out_valid), 64'h0);
        chk("v3_hold_data", 64'(out_data), 64'h2A5A5);
        chk("v3_hold_chan", 64'(out_chan), 64'h2);
        tick();
        chk("v3_still_empty", 64'(out_valid), 64'h0);

        // V4: round-robin from rr_ptr=0 (mode 0 left it untouched)
        mode = 1'b1;
        sel  = 2'd0;
        #1;
        chk("v4_first_grant", 64'(in_ready), 64'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("v4_out_chan", 64'(out_chan), 64'(rr_seq[i]));
            chk("v4_out_data", 64'(out_data), 64'(dat_by_ch[rr_seq[i]]));
            chk("v4_out_valid", 64'(out_valid), 64'h1);
        end

        // V5: backpressure while holding channel 1's beat
        out_ready = 1'b0;
        #1;
        chk("v5_in_ready_bp", 64'(in_ready), 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("v5_hold_data", 64'(out_data), 64'h00011);
            chk("v5_hold_chan", 64'(out_chan), 64'h1);
            chk("v5_hold_valid", 64'(out_valid), 64'h1);
            chk("v5_hold_ready", 64'(in_ready), 64'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("v5_release_ready", 64'(in_ready), 64'h4);
        tick();
        chk("v5_reload_valid", 64'(out_valid), 64'h1);
        chk("v5_reload_chan", 64'(out_chan), 64'h2);
        chk("v5_reload_data", 64'(out_data), 64'h2A5A5);

        // V6: reach FULL with rr_ptr=2, then reset mid-operation
        in_valid = 3'b010;
        #1;
        chk("v6_pre_grant", 64'(in_ready), 64'h2);
        tick();
        chk("v6_pre_chan", 64'(out_chan), 64'h1);
        in_valid = 3'b111;
        #1;
        chk("v6_rr_at_2", 64'(in_ready), 64'h4);
        rst = 1'b1;
        #1;
        chk("v6_rst_ready", 64'(in_ready), 64'h0);
        tick();
        chk("v6_rst_valid", 64'(out_valid), 64'h0);
        chk("v6_rst_data", 64'(out_data), 64'h0);
        chk("v6_rst_chan", 64'(out_chan), 64'h0);
        rst = 1'b0;
        #1;
        chk("v6_post_grant", 64'(in_ready), 64'h1);
        tick();
        chk("v6_post_chan", 64'(out_chan), 64'h0);
        chk("v6_post_data", 64'(out_data), 64'(D0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
